// File: rtl/decode_stage_pkg.sv
// Shared RV32I core types: ALU ops, branch conditions, opcode constants and
// the registered decode bundle handed to execute.
package decode_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_SLL,
        ALU_OP_SLT,
        ALU_OP_SLTU,
        ALU_OP_XOR,
        ALU_OP_SRL,
        ALU_OP_SRA,
        ALU_OP_OR,
        ALU_OP_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE,
        BR_ALWAYS,
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU
    } br_cond_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        word_t    pc;
        alu_op_e  alu_op;
        word_t    imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic     a_sel_pc;
        logic     b_sel_imm;
        logic     rd_we;
        br_cond_e br_cond;
        logic     illegal;
    } decode_bundle_t;

    // alt is funct7[5]; it only matters for funct3 000 (SUB) and 101 (SRA).
    function automatic alu_op_e funct3_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; the format is chosen by opcode.
// OP-IMM shifts yield the zero-extended shamt instead of the I-immediate.
module imm_gen
    import decode_stage_pkg::*;
(
    input  word_t instr,
    output word_t imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3[1:0] == 2'b01)
                    imm = {27'b0, instr[24:20]};
                else
                    imm = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_JALR, OPC_LOAD:
                imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {instr[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: decodes one fetched word per cycle into the
// execute control bundle behind a single valid/ready output register.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  word_t      instr_in,
    input  word_t      pc_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       valid_out,
    input  logic       ready_in,
    input  logic       flush_in,
    output word_t      pc_out,
    output alu_op_e    alu_op_out,
    output word_t      imm_out,
    output logic [4:0] rs1_out,
    output logic [4:0] rs2_out,
    output logic [4:0] rd_out,
    output logic       a_sel_pc_out,
    output logic       b_sel_imm_out,
    output logic       rd_we_out,
    output br_cond_e   br_cond_out,
    output logic       illegal_out
);

    localparam decode_bundle_t RESET_BUNDLE = '{
        pc:        RESET_PC,
        alu_op:    ALU_OP_ADD,
        imm:       32'h0,
        rs1:       5'd0,
        rs2:       5'd0,
        rd:        5'd0,
        a_sel_pc:  1'b0,
        b_sel_imm: 1'b0,
        rd_we:     1'b0,
        br_cond:   BR_NONE,
        illegal:   1'b0
    };

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    word_t          imm;
    logic           wr;
    decode_bundle_t dec;
    decode_bundle_t bundle_q;
    logic           valid_q;
    logic           accept;

    assign opcode = instr_in[6:0];
    assign funct3 = instr_in[14:12];
    assign funct7 = instr_in[31:25];

    imm_gen u_imm_gen (
        .instr (instr_in),
        .imm   (imm)
    );

    always_comb begin
        dec           = RESET_BUNDLE;
        wr            = 1'b0;
        dec.pc        = pc_in;
        dec.imm       = imm;
        dec.rs1       = instr_in[19:15];
        dec.rs2       = instr_in[24:20];
        dec.rd        = instr_in[11:7];
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec.alu_op = funct3_op(funct3, funct7[5]);
                    wr         = 1'b1;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // bit 30 is immediate data for ADDI, so only shifts look at it
                dec.alu_op    = funct3_op(funct3, (funct3 == 3'b101) & instr_in[30]);
                dec.b_sel_imm = 1'b1;
                wr            = 1'b1;
            end
            OPC_LUI: begin
                dec.rs1       = '0;
                dec.b_sel_imm = 1'b1;
                wr            = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                wr            = 1'b1;
            end
            OPC_JAL: begin
                dec.a_sel_pc  = 1'b1;
                dec.b_sel_imm = 1'b1;
                dec.br_cond   = BR_ALWAYS;
                wr            = 1'b1;
            end
            OPC_JALR: begin
                dec.b_sel_imm = 1'b1;
                dec.br_cond   = BR_ALWAYS;
                wr            = 1'b1;
            end
            OPC_LOAD: begin
                dec.b_sel_imm = 1'b1;
                wr            = 1'b1;
            end
            OPC_STORE: begin
                dec.b_sel_imm = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op = ALU_OP_SUB;
                case (funct3)
                    3'b000:  dec.br_cond = BR_EQ;
                    3'b001:  dec.br_cond = BR_NE;
                    3'b100:  dec.br_cond = BR_LT;
                    3'b101:  dec.br_cond = BR_GE;
                    3'b110:  dec.br_cond = BR_LTU;
                    3'b111:  dec.br_cond = BR_GEU;
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.alu_op    = ALU_OP_ADD;
            dec.br_cond   = BR_NONE;
            dec.a_sel_pc  = 1'b0;
            dec.b_sel_imm = 1'b0;
            wr            = 1'b0;
        end
        dec.rd_we = wr & (dec.rd != 5'd0);
    end

    assign ready_out = !valid_q | ready_in;
    assign accept    = valid_in & ready_out & !flush_in;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_q  <= 1'b0;
            bundle_q <= RESET_BUNDLE;
        end else if (flush_in) begin
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            bundle_q <= dec;
        end else if (ready_in) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_out     = valid_q;
    assign pc_out        = valid_q ? bundle_q.pc : RESET_PC;
    assign alu_op_out    = bundle_q.alu_op;
    assign imm_out       = bundle_q.imm;
    assign rs1_out       = bundle_q.rs1;
    assign rs2_out       = bundle_q.rs2;
    assign rd_out        = bundle_q.rd;
    assign a_sel_pc_out  = bundle_q.a_sel_pc;
    assign b_sel_imm_out = bundle_q.b_sel_imm;
    assign rd_we_out     = bundle_q.rd_we;
    assign br_cond_out   = bundle_q.br_cond;
    assign illegal_out   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode table, handshake
// hold, back-to-back streaming, flush and asynchronous reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam word_t RPC = 32'h0000_1000;

    logic       clk_in = 1'b0;
    logic       reset_in;
    word_t      instr_in;
    word_t      pc_in;
    logic       valid_in;
    logic       ready_out;
    logic       valid_out;
    logic       ready_in;
    logic       flush_in;
    word_t      pc_out;
    alu_op_e    alu_op_out;
    word_t      imm_out;
    logic [4:0] rs1_out;
    logic [4:0] rs2_out;
    logic [4:0] rd_out;
    logic       a_sel_pc_out;
    logic       b_sel_imm_out;
    logic       rd_we_out;
    br_cond_e   br_cond_out;
    logic       illegal_out;

    int errors = 0;
    int checks = 0;

    decode_stage #(.RESET_PC(RPC)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .instr_in      (instr_in),
        .pc_in         (pc_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in),
        .flush_in      (flush_in),
        .pc_out        (pc_out),
        .alu_op_out    (alu_op_out),
        .imm_out       (imm_out),
        .rs1_out       (rs1_out),
        .rs2_out       (rs2_out),
        .rd_out        (rd_out),
        .a_sel_pc_out  (a_sel_pc_out),
        .b_sel_imm_out (b_sel_imm_out),
        .rd_we_out     (rd_we_out),
        .br_cond_out   (br_cond_out),
        .illegal_out   (illegal_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        word_t      instr;
        alu_op_e    op;
        word_t      imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       a_pc;
        logic       b_imm;
        logic       we;
        br_cond_e   br;
        logic       ill;
    } vec_t;

    // Fields in the same order as vec_t minus the instruction word.
    function automatic logic [57:0] observed_fields();
        return {alu_op_out, imm_out, rs1_out, rs2_out, rd_out,
                a_sel_pc_out, b_sel_imm_out, rd_we_out, br_cond_out, illegal_out};
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        valid_in = 1'b1;
        instr_in = 32'h002081B3;
        pc_in    = 32'h0000_0040;
        ready_in = 1'b0;
        flush_in = 1'b0;
        tick();
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_out);
        end
        checks++;
        if (ready_out !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", ready_out);
        end
        checks++;
        if ({pc_out, observed_fields()} !== {RPC, ALU_OP_ADD, 32'h0, 15'h0, 3'b000, BR_NONE, 1'b0}) begin
            errors++; $display("FAIL reset_bundle: got pc=%h f=%h want pc=%h f=0", pc_out, observed_fields(), RPC);
        end
        #3 reset_in = 1'b0;
        valid_in = 1'b0;
        tick();
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL post_reset: got valid=%b ready=%b want 0/1", valid_out, ready_out);
        end
    endtask

    task automatic test_decode();
        vec_t vecs[14];
        vecs = '{
            '{32'h002081B3, ALU_OP_ADD, 32'h0,        5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 1'b1, BR_NONE,   1'b0},
            '{32'h402081B3, ALU_OP_SUB, 32'h0,        5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 1'b1, BR_NONE,   1'b0},
            '{32'h40335293, ALU_OP_SRA, 32'h3,        5'd6,  5'd3,  5'd5, 1'b0, 1'b1, 1'b1, BR_NONE,   1'b0},
            '{32'h0020C463, ALU_OP_SUB, 32'h8,        5'd1,  5'd2,  5'd8, 1'b0, 1'b0, 1'b0, BR_LT,     1'b0},
            '{32'h123450B7, ALU_OP_ADD, 32'h12345000, 5'd0,  5'd3,  5'd1, 1'b0, 1'b1, 1'b1, BR_NONE,   1'b0},
            '{32'h40000093, ALU_OP_ADD, 32'h400,      5'd0,  5'd0,  5'd1, 1'b0, 1'b1, 1'b1, BR_NONE,   1'b0},
            '{32'h00000013, ALU_OP_ADD, 32'h0,        5'd0,  5'd0,  5'd0, 1'b0, 1'b1, 1'b0, BR_NONE,   1'b0},
            '{32'hFFDFF0EF, ALU_OP_ADD, 32'hFFFFFFFC, 5'd31, 5'd29, 5'd1, 1'b1, 1'b1, 1'b1, BR_ALWAYS, 1'b0},
            '{32'h0020A423, ALU_OP_ADD, 32'h8,        5'd1,  5'd2,  5'd8, 1'b0, 1'b1, 1'b0, BR_NONE,   1'b0},
            '{32'h00001117, ALU_OP_ADD, 32'h1000,     5'd0,  5'd0,  5'd2, 1'b1, 1'b1, 1'b1, BR_NONE,   1'b0},
            '{32'h0020F463, ALU_OP_SUB, 32'h8,        5'd1,  5'd2,  5'd8, 1'b0, 1'b0, 1'b0, BR_GEU,    1'b0},
            '{32'h0000007F, ALU_OP_ADD, 32'h0,        5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, BR_NONE,   1'b1},
            '{32'h022081B3, ALU_OP_ADD, 32'h0,        5'd1,  5'd2,  5'd3, 1'b0, 1'b0, 1'b0, BR_NONE,   1'b1},
            '{32'h0020A463, ALU_OP_ADD, 32'h8,        5'd1,  5'd2,  5'd8, 1'b0, 1'b0, 1'b0, BR_NONE,   1'b1}
        };
        ready_in = 1'b1;
        for (int i = 0; i < 14; i++) begin
            valid_in = 1'b1;
            instr_in = vecs[i].instr;
            pc_in    = 32'h0000_0400 + 32'(i * 4);
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h0000_0400 + 32'(i * 4)) begin
                errors++; $display("FAIL decode_handshake[%0d]: got valid=%b pc=%h want 1 pc=%h",
                                   i, valid_out, pc_out, 32'h0000_0400 + 32'(i * 4));
            end
            checks++;
            if (observed_fields() !== vecs[i][57:0]) begin
                errors++; $display("FAIL decode_fields[%0d] instr=%h: got %h want %h",
                                   i, vecs[i].instr, observed_fields(), vecs[i][57:0]);
            end
        end
        valid_in = 1'b0;
        tick();
        checks++;
        if (valid_out !== 1'b0 || pc_out !== RPC) begin
            errors++; $display("FAIL decode_drain: got valid=%b pc=%h want 0 pc=%h", valid_out, pc_out, RPC);
        end
    endtask

    task automatic test_hold();
        ready_in = 1'b0;
        valid_in = 1'b1;
        instr_in = 32'h002081B3;
        pc_in    = 32'h0000_0800;
        tick();
        instr_in = 32'h40335293;
        pc_in    = 32'h0000_0804;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ready_out !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h0000_0800 ||
                rd_out !== 5'd3 || alu_op_out !== ALU_OP_ADD || b_sel_imm_out !== 1'b0) begin
                errors++; $display("FAIL hold[%0d]: got ready=%b valid=%b pc=%h rd=%0d op=%0d want 0 1 800 3 0",
                                   c, ready_out, valid_out, pc_out, rd_out, alu_op_out);
            end
            tick();
        end
        ready_in = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b1 || pc_out !== 32'h0000_0800) begin
            errors++; $display("FAIL hold_release: got ready=%b pc=%h want 1 pc=800", ready_out, pc_out);
        end
        tick();
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h0000_0804 || alu_op_out !== ALU_OP_SRA || rd_out !== 5'd5) begin
            errors++; $display("FAIL hold_newload: got valid=%b pc=%h op=%0d rd=%0d want 1 804 SRA 5",
                               valid_out, pc_out, alu_op_out, rd_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL hold_consume: got valid=%b want 0", valid_out);
        end
    endtask

    task automatic test_back_to_back();
        word_t stream[4];
        stream = '{32'h002081B3, 32'h402081B3, 32'h40335293, 32'h123450B7};
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            instr_in = stream[i];
            pc_in    = 32'h0000_0200 + 32'(i * 4);
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h0000_0200 + 32'(i * 4) || rd_out !== stream[i][11:7]) begin
                errors++; $display("FAIL stream[%0d]: got valid=%b pc=%h rd=%0d want 1 pc=%h rd=%0d",
                                   i, valid_out, pc_out, rd_out, 32'h0000_0200 + 32'(i * 4), stream[i][11:7]);
            end
        end
        instr_in = 32'h0020C463;
        pc_in    = 32'h0000_0210;
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL flush_valid: got %b want 0", valid_out);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0 || pc_out !== RPC) begin
            errors++; $display("FAIL flush_dropped: got valid=%b pc=%h want 0 pc=%h", valid_out, pc_out, RPC);
        end
        // flush while holding a stalled bundle
        ready_in = 1'b0;
        valid_in = 1'b1;
        instr_in = 32'h002081B3;
        pc_in    = 32'h0000_0300;
        tick();
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        valid_in = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            errors++; $display("FAIL flush_stalled: got valid=%b ready=%b want 0 1", valid_out, ready_out);
        end
    endtask

    task automatic test_async_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        instr_in = 32'h0020C463;
        pc_in    = 32'h0000_0500;
        tick();
        checks++;
        if (valid_out !== 1'b1 || br_cond_out !== BR_LT) begin
            errors++; $display("FAIL areset_pre: got valid=%b br=%0d want 1 LT", valid_out, br_cond_out);
        end
        #2 reset_in = 1'b1;
        #1;
        checks++;
        if ({valid_out, ready_out, pc_out, observed_fields()} !==
            {1'b0, 1'b1, RPC, ALU_OP_ADD, 32'h0, 15'h0, 3'b000, BR_NONE, 1'b0}) begin
            errors++; $display("FAIL areset_clear: got valid=%b ready=%b pc=%h f=%h want 0 1 pc=%h f=0",
                               valid_out, ready_out, pc_out, observed_fields(), RPC);
        end
        tick();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++; $display("FAIL areset_noaccept: got valid=%b want 0", valid_out);
        end
        #2 reset_in = 1'b0;
        valid_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode pipeline stage for the RV32I core. It sits upstream of the ALU, consumes fetched instruction words and produces the control bundle the execute stage needs. That bundle is the ALU operation code, operand selects, immediate, register indices, and the branch condition that execute evaluates against the ALU Z/N/V/C/S flags. It has valid/ready handshakes on both sides, a flush input, and a single output register (1-cycle latency).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, value of `pc_out` while no valid entry is held.

Ports:
- clk_in  input  1  core clock, all state on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- instr_in  input  32 (word_t)  fetched instruction.
- pc_in  input  32 (word_t)  address of `instr_in`.
- valid_in  input  1  fetch offers `instr_in`/`pc_in`.
- ready_out  output  1  stage accepts this cycle.
- valid_out  output  1  output bundle valid.
- ready_in  input  1  execute consumes bundle this cycle.
- flush_in  input  1  discard held and offered instruction.
- pc_out  output  32  pc of held instruction.
- alu_op_out  output  alu_op_e  ALU operation.
- imm_out  output  32  sign-extended immediate.
- rs1_out, rs2_out, rd_out  output  5 each  register indices.
- a_sel_pc_out  output  1  ALU A = pc, else rs1.
- b_sel_imm_out  output  1  ALU B = imm, else rs2.
- rd_we_out  output  1  writes rd (forced 0 when rd = x0).
- br_cond_out  output  br_cond_e  branch/jump condition.
- illegal_out  output  1  unsupported encoding.

## Operation
- Accept = `valid_in & ready_out`. `ready_out = !valid_out | ready_in`, combinational, no dependency on `valid_in`.
- On accept, the decoded bundle loads into the output register and `valid_out` is set.
- If `valid_out & ready_in` and there is no accept, `valid_out` clears.
- If not ready, the bundle holds bit-stable.
- Opcode decode:
  - OP (0110011): the op comes from the funct3 map. funct7[5] selects SUB for funct3 000 and SRA for 101. A/B = rs1/rs2. rd_we = 1.
  - OP-IMM (0010011): the same map, except funct3 000 is always ADD. imm = I-type. For shifts, imm = zero-extended shamt and funct7[5] selects SRA.
  - funct3 map: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA, 110 OR, 111 AND.
  - LUI: ADD with A = 0 (rs1_out = 0), imm = U-type.
  - AUIPC: ADD, A = pc, imm = U-type.
  - JAL: ADD, A = pc, imm = J-type, br_cond = ALWAYS. The link value is computed elsewhere.
  - JALR: ADD, rs1 + I-imm, br_cond = ALWAYS.
  - LOAD: ADD, I-imm. STORE: ADD, S-imm, rd_we = 0.
  - BRANCH: SUB, A/B = rs1/rs2, imm = B-type, rd_we = 0. Condition: BEQ→EQ (Z), BNE→NE (!Z), BLT→LT (S), BGE→GE (!S), BLTU→LTU (C, the SUB borrow), BGEU→GEU (!C). funct3 010/011 is illegal.
- br_cond is NONE for non-control-flow instructions.
- Illegal encoding (unknown opcode, bad funct7 on OP, bad branch funct3): bundle is valid with illegal_out = 1, op ADD, rd_we = 0, br_cond NONE.
- Flush: synchronous, with priority over everything. The cycle it is asserted, no accept occurs and `valid_out` clears next edge. `ready_out` still reads as computed, but fetch treats the flushed offer as dropped.

## Timing
- Latency is 1 cycle. Full throughput of 1/cycle when `ready_in` is held high.
- Reset values: valid_out 0, pc_out RESET_PC, alu_op_out ALU_OP_ADD, imm/rs/rd 0, selects 0, rd_we 0, br_cond NONE, illegal 0. `ready_out` = 1 during and after reset.
- Reset asserted mid-hold: the bundle is lost immediately (asynchronous). Nothing is accepted while reset is high.
- Simultaneous consume and accept: the new bundle replaces the old one with no bubble.
- Flush concurrent with consume: the consume completes and nothing new loads.

## Structure
- Shared core package holds `alu_op_e` (existing), new `br_cond_e` {NONE, ALWAYS, EQ, NE, LT, GE, LTU, GEU}, RV32I opcode constants, and `decode_bundle_t`.
- Sub-module `imm_gen`: combinational I/S/B/U/J immediate extraction selected by opcode.
- The output register and handshake live in `decode_stage`.

## Test plan
- `0x002081B3` (add x3,x1,x2), ready_in = 1 → next cycle: valid_out, ADD, rs1 = 1, rs2 = 2, rd = 3, b_sel_imm = 0, rd_we = 1.
- `0x402081B3` → SUB. `0x40335293` (srai x5,x6,3) → SRA, imm = 3, rs1 = 6, rd = 5, b_sel_imm = 1.
- `0x0020C463` (blt x1,x2,+8) → SUB, br_cond LT, imm = 8, rd_we = 0. `0x123450B7` (lui x1,0x12345) → imm = 0x12345000, ADD.
- Hold ready_in = 0 for 3 cycles with a valid bundle → ready_out = 0 and the bundle stays stable. A new instr offered meanwhile loads only on the cycle after ready_in rises.
- Back-to-back stream of 4 instructions with ready_in = 1 → 4 consecutive valid cycles, in order, no bubble. Flush mid-stream → valid_out = 0 next cycle and the offered word is dropped.
- Opcode `0x0000007F` → illegal_out = 1, rd_we = 0. Async reset pulse while valid_out = 1 → all outputs return to reset values before the next edge.
